uart_tx_scheduler: RTL and testbench

Shares the single UART transmitter between several byte producers. Arbitrates among them round-robin, one byte at a time. Generates the baud-rate strobe that clocks the transmitter. Drives the transmitter's Enable/DataIn, then holds off further grants until the full 12-bit frame (start, 8 data, even parity, 2 stop) has left the line.

---
 rtl/uart_tx_scheduler_if.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 148 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Producer-side handshake and transmitter-side signals of the UART TX scheduler.
interface uart_tx_scheduler_if #(
  parameter int NumRequesters = 4
);
  localparam int GW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

  logic [NumRequesters-1:0]   ReqValid;
  logic [8*NumRequesters-1:0] ReqData;
  logic [NumRequesters-1:0]   ReqReady;
  logic                       BaudStrobe;
  logic                       TxEnable;
  logic [7:0]                 TxData;
  logic                       Busy;
  logic [GW-1:0]              GrantIndex;

  // Producers and observers of the scheduler
  modport master (
    output ReqValid, ReqData,
    input  ReqReady, BaudStrobe, TxEnable, TxData, Busy, GrantIndex
  );

  // The scheduler itself
  modport slave (
    input  ReqValid, ReqData,
    output ReqReady, BaudStrobe, TxEnable, TxData, Busy, GrantIndex
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between several byte
// producers. Generates the baud strobe, loads one byte per frame and blocks
// further grants until the 12-bit frame has left the line.
module uart_tx_scheduler #(
  parameter int NumRequesters = 4,
  parameter int ClockDivider  = 16,
  parameter int FrameTicks    = 13
) (
  input  logic               Clock,
  input  logic               Reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int GW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int BW = $clog2(ClockDivider) + 1;
  localparam int FW = $clog2(FrameTicks) + 1;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(ClockDivider - 1);
  localparam logic [FW-1:0] FRAME_INIT = FW'(FrameTicks);
  localparam logic [GW-1:0] LAST_REQ   = GW'(NumRequesters - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [BW-1:0]            baud_cnt_q, baud_cnt_d;
  logic                     strobe_q, strobe_d;
  logic [1:0]               state_q, state_d;
  logic [FW-1:0]            frame_cnt_q, frame_cnt_d;
  logic [GW-1:0]            ptr_q, ptr_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_en_q, tx_en_d;
  logic                     busy_q, busy_d;
  logic [NumRequesters-1:0] ready_q, ready_d;

  logic                     found;
  logic [GW-1:0]            winner;
  int                       scan_idx;

  // Free-running baud divider; strobe is registered on the terminal count
  always_comb begin
    strobe_d = (baud_cnt_q == BAUD_LAST);
    if (baud_cnt_q == BAUD_LAST) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + 1'b1;
    end
  end

  // First valid requester at or above the pointer, wrapping around
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int k = 0; k < NumRequesters; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NumRequesters) begin
        scan_idx = scan_idx - NumRequesters;
      end
      if (!found && bus.ReqValid[scan_idx]) begin
        found  = 1'b1;
        winner = GW'(scan_idx);
      end
    end
  end

  // Grant / load / frame-wait sequencing
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    tx_en_d     = tx_en_q;
    busy_d      = busy_q;
    ready_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          tx_data_d = bus.ReqData[8*int'(winner) +: 8];
          ready_d   = NumRequesters'(1) << winner;
          grant_d   = winner;
          ptr_d     = (winner == LAST_REQ) ? '0 : winner + 1'b1;
          tx_en_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        // The transmitter latches the byte on the baud strobe
        if (strobe_q) begin
          tx_en_d     = 1'b0;
          frame_cnt_d = FRAME_INIT;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (strobe_q) begin
          if (frame_cnt_q == FW'(1)) begin
            frame_cnt_d = '0;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      baud_cnt_q  <= '0;
      strobe_q    <= 1'b0;
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      tx_data_q   <= '0;
      tx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= '0;
    end else begin
      baud_cnt_q  <= baud_cnt_d;
      strobe_q    <= strobe_d;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      tx_data_q   <= tx_data_d;
      tx_en_q     <= tx_en_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.ReqReady   = ready_q;
  assign bus.BaudStrobe = strobe_q;
  assign bus.TxEnable   = tx_en_q;
  assign bus.TxData     = tx_data_q;
  assign bus.Busy       = busy_q;
  assign bus.GrantIndex = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a round-robin reference model
// predicts the grant order, a monitor compares every accept and frame timing.
module tb_uart_tx_scheduler;
  localparam int N   = 4;
  localparam int CD  = 4;
  localparam int FT  = 13;
  localparam int N3  = 3;
  localparam int CD3 = 2;
  localparam int FT3 = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  uart_tx_scheduler_if #(.NumRequesters(N))  bus ();
  uart_tx_scheduler_if #(.NumRequesters(N3)) bus3 ();

  uart_tx_scheduler #(.NumRequesters(N), .ClockDivider(CD), .FrameTicks(FT)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );
  uart_tx_scheduler #(.NumRequesters(N3), .ClockDivider(CD3), .FrameTicks(FT3)) dut3 (
    .Clock(Clock), .Reset(Reset), .bus(bus3)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic [7:0] prod_q[N][$];   // bytes each producer still has to send
  logic [7:0] mdl_q[N][$];    // model's copy of pending bytes
  exp_t       exp_q[$];       // predicted accept order
  int         model_ptr = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic give(input int i, input logic [7:0] b);
    prod_q[i].push_back(b);
    mdl_q[i].push_back(b);
  endtask

  // Round-robin: each frame serves the first producer with a pending byte at or after the pointer
  task automatic model_schedule();
    bit any;
    do begin
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (model_ptr + k) % N;
        if (mdl_q[i].size() > 0) begin
          exp_t e;
          e.idx  = i;
          e.data = mdl_q[i].pop_front();
          exp_q.push_back(e);
          model_ptr = (i + 1) % N;
          any = 1'b1;
          break;
        end
      end
    end while (any);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.Busy || bus.ReqValid != '0) && t < 5000) begin
      @(posedge Clock);
      t++;
    end
    if (t >= 5000) begin
      tests++;
      fails++;
      $display("FAIL wait_idle_timeout: pending %0d expected 0", exp_q.size());
    end
    repeat (3) @(posedge Clock);
  endtask

  // Producers: drop the accepted byte, then present the next one
  initial begin
    bus.ReqValid = '0;
    bus.ReqData  = '0;
    forever begin
      @(posedge Clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (bus.ReqReady[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
      end
      for (int i = 0; i < N; i++) begin
        bus.ReqValid[i]      = (prod_q[i].size() > 0);
        bus.ReqData[8*i +: 8] = (prod_q[i].size() > 0) ? prod_q[i][0] : 8'h00;
      end
    end
  end

  // Second instance: all three requesters permanently valid
  initial begin
    bus3.ReqValid = '1;
    for (int i = 0; i < N3; i++) bus3.ReqData[8*i +: 8] = 8'(8'hC0 + i);
  end

  int g3 = 0;
  // Accept order of the three-requester instance
  always @(negedge Clock) begin
    if (Reset && bus3.ReqReady != '0 && g3 < 5) begin
      check("n3_ready", 32'(bus3.ReqReady), 32'(1) << (g3 % N3));
      check("n3_grant_index", 32'(bus3.GrantIndex), g3 % N3);
      check("n3_tx_data", 32'(bus3.TxData), 8'hC0 + (g3 % N3));
      g3++;
    end
  end

  int         cyc = 0;
  int         last_strobe, last_grant, load_len, busy_strobes;
  bit         have_strobe, have_grant, prev_busy, prev_txen, prev_strobe;
  logic [7:0] prev_txdata;

  // Monitor: pops the scoreboard on every accept and checks frame timing
  always @(negedge Clock) begin
    cyc++;
    if (!Reset) begin
      have_strobe  = 1'b0;
      have_grant   = 1'b0;
      busy_strobes = 0;
      load_len     = 0;
      prev_busy    = 1'b0;
      prev_txen    = 1'b0;
      prev_strobe  = 1'b0;
      prev_txdata  = 8'h00;
    end else begin
      if (bus.BaudStrobe) begin
        if (have_strobe) check("baud_period", cyc - last_strobe, CD);
        last_strobe = cyc;
        have_strobe = 1'b1;
      end
      if (bus.ReqReady != '0) begin
        check("ready_onehot", $countones(bus.ReqReady), 1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_grant: got ready %0h expected none", bus.ReqReady);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("grant_ready", 32'(bus.ReqReady), 32'(1) << e.idx);
          check("grant_index", 32'(bus.GrantIndex), e.idx);
          check("grant_data", 32'(bus.TxData), 32'(e.data));
          check("grant_txen", 32'(bus.TxEnable), 1);
          check("grant_busy", 32'(bus.Busy), 1);
        end
        if (have_grant) check("grant_spacing", 32'((cyc - last_grant) >= 1 + FT * CD), 1);
        last_grant   = cyc;
        have_grant   = 1'b1;
        load_len     = 0;
        busy_strobes = 0;
      end else begin
        check("txdata_hold", 32'(bus.TxData), 32'(prev_txdata));
      end
      if (bus.TxEnable) load_len++;
      if (prev_txen && !bus.TxEnable) begin
        check("load_ends_on_strobe", 32'(prev_strobe), 1);
        check("load_len_max", 32'(load_len <= CD), 1);
      end
      if (bus.Busy && !bus.TxEnable && bus.BaudStrobe) busy_strobes++;
      if (prev_busy && !bus.Busy) check("busy_strobes", busy_strobes, FT);
      prev_busy   = bus.Busy;
      prev_txen   = bus.TxEnable;
      prev_strobe = bus.BaudStrobe;
      prev_txdata = bus.TxData;
    end
  end

  // Hard stop if something wedges
  initial begin
    #800000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    Reset = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_ready", 32'(bus.ReqReady), 0);
    check("rst_strobe", 32'(bus.BaudStrobe), 0);
    check("rst_txen", 32'(bus.TxEnable), 0);
    check("rst_txdata", 32'(bus.TxData), 0);
    check("rst_busy", 32'(bus.Busy), 0);
    check("rst_grant_index", 32'(bus.GrantIndex), 0);
    Reset = 1'b1;

    // Single byte from requester 0
    give(0, 8'hA5);
    model_schedule();
    wait_idle();

    // Everyone valid, requester 0 has a second byte
    give(0, 8'h10); give(1, 8'h21); give(2, 8'h32); give(3, 8'h43); give(0, 8'h54);
    model_schedule();
    wait_idle();

    // Pointer wrap: grant 2, then 3 and 0, then a late requester 1
    give(2, 8'h77);
    model_schedule();
    wait_idle();
    give(3, 8'h88); give(0, 8'h99);
    model_schedule();
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge Clock);
      t++;
    end
    repeat (5) @(posedge Clock);
    give(1, 8'h11);
    model_schedule();
    wait_idle();

    // Random bursts
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) give(i, 8'($urandom));
      end
      model_schedule();
      wait_idle();
    end

    // Reset two cycles into WAIT of the first frame
    for (int i = 0; i < N; i++) begin
      give(i, 8'($urandom));
      give(i, 8'($urandom));
    end
    model_schedule();
    t = 0;
    while (!(bus.Busy && !bus.TxEnable) && t < 500) begin
      @(posedge Clock);
      t++;
    end
    if (t >= 500) begin
      tests++;
      fails++;
      $display("FAIL wait_state_timeout: got busy %0d expected 1", bus.Busy);
    end
    repeat (2) @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.Busy), 0);
    check("async_rst_txen", 32'(bus.TxEnable), 0);
    check("async_rst_ready", 32'(bus.ReqReady), 0);
    check("async_rst_txdata", 32'(bus.TxData), 0);
    check("async_rst_grant_index", 32'(bus.GrantIndex), 0);
    repeat (2) @(negedge Clock);
    exp_q.delete();
    for (int i = 0; i < N; i++) mdl_q[i] = prod_q[i];
    model_ptr = 0;
    model_schedule();
    Reset = 1'b1;
    wait_idle();

    check("n3_grant_count", g3, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
